compressor_ctrl: RTL and testbench
==================================

Name: compressor_ctrl

Overview:
- Downstream consumer of the threshold comparator's one-bit demand output (signal_o, which is high when the temperature difference exceeds threshold).
- Debounces the demand and drives the compressor and evaporator fan enables.
- Enforces anti-short-cycle protection: minimum on-time, minimum off-time (lockout) and fan run-on after compressor stop.
- Sits between the comparator stage and the board output pins.

Parameters:
- TICK_DIV, 50000: clock cycles per timer tick; min 1.
- DEBOUNCE_CYC, 16: consecutive cycles demand_i must differ from filtered demand before it is accepted; min 1.
- MIN_ON_TICKS, 600: minimum compressor run time in ticks; min 1.
- MIN_OFF_TICKS, 600: compressor lockout after fan run-on, in ticks; min 1.
- RUNON_TICKS, 100: fan run-on after compressor stop, in ticks; min 1.
- TW, 16: width of the tick timer; must hold max(tick params)-1.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- start_i  input  1  system enable; low forces shutdown path.
- demand_i  input  1  raw cooling demand from comparator signal_o.
- compressor_o  output  1  compressor enable.
- fan_o  output  1  fan enable.
- state_o  output  3  current FSM state code, for status display.
- demand_q_o  output  1  debounced demand.

Behaviour:
- Reset: one clock; reset is synchronous and active-low, via rst_ni sampled on the rising edge of clk_i. While rst_ni=0 at an edge:
  - state=OFF_LOCK; prescaler, timer, debounce counter and demand_q cleared to 0.
  - compressor_o=0, fan_o=0, state_o=0, demand_q_o=0.
  - Reset mid-operation takes effect at that edge with no run-on. The lockout is then served from the start.
- Debounce:
  - Counter increments on each edge where demand_i != demand_q, and clears on any edge where they are equal.
  - When demand_i has differed on DEBOUNCE_CYC consecutive edges, demand_q <= demand_i at that edge and the counter clears.
  - Pulses shorter than DEBOUNCE_CYC cycles are ignored entirely.
- Timer:
  - The prescaler and the tick timer both clear on every state transition.
  - The prescaler counts 0..TICK_DIV-1 and emits a tick on wrap. The timer increments on each tick.
  - A state with a dwell of N ticks exits at the edge where tick=1 and timer=N-1. The dwell is therefore exactly N*TICK_DIV cycles from the entry edge.
- States and codes:
  - OFF_LOCK (0): compressor and fan off. Exits after MIN_OFF_TICKS -> OFF_READY. Ignores demand and start_i.
  - OFF_READY (1): compressor and fan off. If start_i=1 and demand_q=1 -> ON_MIN on the next edge.
  - ON_MIN (2): compressor and fan on. If start_i=0 -> FAN_RUNON (safety override of the minimum on-time). Otherwise, after MIN_ON_TICKS -> ON_HOLD. Loss of demand is ignored here.
  - ON_HOLD (3): compressor and fan on. If start_i=0 or demand_q=0 -> FAN_RUNON.
  - FAN_RUNON (4): compressor off, fan on. Exits after RUNON_TICKS -> OFF_LOCK. Demand and start_i are ignored.
- Outputs:
  - Decoded directly from the state register, so they change at the same edge as the state.
  - compressor_o = ON_MIN or ON_HOLD.
  - fan_o = ON_MIN, ON_HOLD or FAN_RUNON.
  - state_o = state code.
  - Codes 5-7 are illegal and recover to OFF_LOCK on the next edge with both outputs 0.
- Latency:
  - A demand step reaches compressor_o (from OFF_READY) DEBOUNCE_CYC+1 edges after demand_i first differs.
  - start_i is not debounced; it is acted on at the next edge.
- Simultaneous events:
  - In ON_MIN, start_i=0 on the same edge as min-on expiry goes to FAN_RUNON.
  - In ON_HOLD, demand_q falling together with start_i falling gives a single FAN_RUNON entry.
- The compressor is never on without the fan. compressor_o can never go 0->1 without passing through OFF_LOCK for a full MIN_OFF_TICKS since the previous stop.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_CYC=3, MIN_ON=3, MIN_OFF=2, RUNON=2.
- Reset/lockout: rst_ni=0 for 3 cycles with start_i=1 and demand_i=1 -> outputs 0 and state_o=0. After release: state_o=0 for 8 cycles, then 1 for one edge, then 2 with compressor_o=fan_o=1.
- Glitch reject: in OFF_READY with start_i=1, demand_i high for 2 cycles -> demand_q_o stays 0, state_o stays 1. Demand_i high for 3 cycles -> demand_q_o=1 on the 3rd edge, state_o=2 on the 4th.
- Min-on hold: demand drops 1 cycle after ON_MIN entry -> compressor_o stays 1 until 12 cycles after entry. Then state 3 for DEBOUNCE-resolved 1 edge, then FAN_RUNON with compressor_o=0, fan_o=1 for 8 cycles, then OFF_LOCK with fan_o=0.
- Safety stop: start_i=0 during ON_MIN -> next edge state_o=4, compressor_o=0, fan_o=1.
- Re-demand during run-on/lockout: demand_i=1 throughout FAN_RUNON and OFF_LOCK -> compressor_o stays 0 for 16 cycles, then OFF_READY one edge, then ON_MIN.
- Mid-run reset: rst_ni=0 for 1 edge in ON_HOLD -> at that edge compressor_o=0, fan_o=0, state_o=0. A full 8-cycle lockout follows.

Source files
------------

// File: rtl/compressor_ctrl.sv
// Compressor/fan sequencer: debounces the comparator demand and
// enforces min-on, fan run-on and min-off lockout before restart.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   start_i      system enable; low forces the shutdown path
//   demand_i     raw cooling demand from the comparator
//   compressor_o compressor enable
//   fan_o        evaporator fan enable
//   state_o      current state code for status display
//   demand_q_o   debounced demand
module compressor_ctrl #(
    parameter int TICK_DIV      = 50000,
    parameter int DEBOUNCE_CYC  = 16,
    parameter int MIN_ON_TICKS  = 600,
    parameter int MIN_OFF_TICKS = 600,
    parameter int RUNON_TICKS   = 100,
    parameter int TW            = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       demand_i,
    output logic       compressor_o,
    output logic       fan_o,
    output logic [2:0] state_o,
    output logic       demand_q_o
);

    localparam logic [2:0] OFF_LOCK  = 3'd0;
    localparam logic [2:0] OFF_READY = 3'd1;
    localparam logic [2:0] ON_MIN    = 3'd2;
    localparam logic [2:0] ON_HOLD   = 3'd3;
    localparam logic [2:0] FAN_RUNON = 3'd4;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(MIN_ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(MIN_OFF_TICKS - 1);
    localparam logic [TW-1:0] RUN_LAST = TW'(RUNON_TICKS - 1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [PW-1:0] psc_q;
    logic [TW-1:0] tmr_q;
    logic [DW-1:0] deb_q;
    logic          demand_q;
    logic          tick;

    assign tick = (psc_q == PSC_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF_LOCK: begin
                if (tick && tmr_q == OFF_LAST)
                    state_d = OFF_READY;
            end
            OFF_READY: begin
                if (start_i && demand_q)
                    state_d = ON_MIN;
            end
            ON_MIN: begin
                // start_i low overrides the minimum on-time
                if (!start_i)
                    state_d = FAN_RUNON;
                else if (tick && tmr_q == ON_LAST)
                    state_d = ON_HOLD;
            end
            ON_HOLD: begin
                if (!start_i || !demand_q)
                    state_d = FAN_RUNON;
            end
            FAN_RUNON: begin
                if (tick && tmr_q == RUN_LAST)
                    state_d = OFF_LOCK;
            end
            default: state_d = OFF_LOCK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= OFF_LOCK;
            psc_q    <= '0;
            tmr_q    <= '0;
            deb_q    <= '0;
            demand_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // every dwell is timed from its own entry edge
            if (state_d != state_q) begin
                psc_q <= '0;
                tmr_q <= '0;
            end else if (tick) begin
                psc_q <= '0;
                tmr_q <= tmr_q + 1'b1;
            end else begin
                psc_q <= psc_q + 1'b1;
            end

            if (demand_i == demand_q) begin
                deb_q <= '0;
            end else if (deb_q == DEB_LAST) begin
                demand_q <= demand_i;
                deb_q    <= '0;
            end else begin
                deb_q <= deb_q + 1'b1;
            end
        end
    end

    assign compressor_o = (state_q == ON_MIN) ||
                          (state_q == ON_HOLD);
    assign fan_o        = compressor_o ||
                          (state_q == FAN_RUNON);
    assign state_o      = state_q;
    assign demand_q_o   = demand_q;

endmodule

// File: tb/tb_compressor_ctrl.sv
// Bench for compressor_ctrl: per-cycle stimulus with expected
// outputs queued on drive and popped after each rising edge.
module tb_compressor_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       start_i;
    logic       demand_i;
    logic       compressor_o;
    logic       fan_o;
    logic [2:0] state_o;
    logic       demand_q_o;

    int total;
    int bad;
    int cyc;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       dm;
        logic [5:0] ex;
    } stim_t;

    stim_t      stim_q[$];
    logic [5:0] sb_q[$];

    compressor_ctrl #(
        .TICK_DIV(4),
        .DEBOUNCE_CYC(3),
        .MIN_ON_TICKS(3),
        .MIN_OFF_TICKS(2),
        .RUNON_TICKS(2),
        .TW(16)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .start_i(start_i),
        .demand_i(demand_i),
        .compressor_o(compressor_o),
        .fan_o(fan_o),
        .state_o(state_o),
        .demand_q_o(demand_q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] mk(int st, bit c, bit f, bit d);
        logic [31:0] s;
        s = st;
        return {s[2:0], c, f, d};
    endfunction

    // queue n cycles of identical stimulus and expectation
    task automatic add(bit r, bit s, bit d, int n, logic [5:0] e);
        stim_t t;
        t.rst = r;
        t.st  = s;
        t.dm  = d;
        t.ex  = e;
        for (int i = 0; i < n; i++) stim_q.push_back(t);
    endtask

    task automatic test_reset();
        stim_t s;
        logic [5:0] obs, exp;
        add(0, 1, 1, 3, mk(0, 0, 0, 0));
        add(1, 1, 1, 2, mk(0, 0, 0, 0));
        add(1, 1, 1, 5, mk(0, 0, 0, 1));
        add(1, 1, 1, 1, mk(1, 0, 0, 1));
        add(1, 1, 1, 1, mk(2, 1, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_min_on();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 1, 0, 2, mk(2, 1, 1, 1));
        add(1, 1, 0, 9, mk(2, 1, 1, 0));
        add(1, 1, 0, 1, mk(3, 1, 1, 0));
        add(1, 1, 0, 8, mk(4, 0, 1, 0));
        add(1, 1, 0, 1, mk(0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL min_on cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 1, 0, 7, mk(0, 0, 0, 0));
        add(1, 1, 0, 1, mk(1, 0, 0, 0));
        add(1, 1, 1, 2, mk(1, 0, 0, 0));
        add(1, 1, 0, 2, mk(1, 0, 0, 0));
        add(1, 1, 1, 2, mk(1, 0, 0, 0));
        add(1, 1, 1, 1, mk(1, 0, 0, 1));
        add(1, 1, 1, 1, mk(2, 1, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_safety_stop();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 0, 1, 1, mk(4, 0, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL safety cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_redemand();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 1, 1, 7, mk(4, 0, 1, 1));
        add(1, 1, 1, 8, mk(0, 0, 0, 1));
        add(1, 1, 1, 1, mk(1, 0, 0, 1));
        add(1, 1, 1, 1, mk(2, 1, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL redemand cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_midrun_reset();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 1, 1, 11, mk(2, 1, 1, 1));
        add(1, 1, 1, 3, mk(3, 1, 1, 1));
        add(0, 1, 1, 1, mk(0, 0, 0, 0));
        add(1, 1, 1, 2, mk(0, 0, 0, 0));
        add(1, 1, 1, 5, mk(0, 0, 0, 1));
        add(1, 1, 1, 1, mk(1, 0, 0, 1));
        add(1, 1, 1, 1, mk(2, 1, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midrun cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_stop_at_expiry();
        stim_t s;
        logic [5:0] obs, exp;
        add(1, 1, 1, 11, mk(2, 1, 1, 1));
        add(1, 0, 1, 1, mk(4, 0, 1, 1));
        add(1, 1, 1, 7, mk(4, 0, 1, 1));
        add(1, 1, 1, 1, mk(0, 0, 0, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_ni = s.rst; start_i = s.st; demand_i = s.dm;
            sb_q.push_back(s.ex);
            @(posedge clk_i); #1; cyc++;
            obs = {state_o, compressor_o, fan_o, demand_q_o};
            exp = sb_q.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL expiry cyc=%0d got={st,c,f,dq}=%b want=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst_ni   = 1'b0;
        start_i  = 1'b1;
        demand_i = 1'b1;
        test_reset();
        test_min_on();
        test_glitch();
        test_safety_stop();
        test_redemand();
        test_midrun_reset();
        test_stop_at_expiry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
